// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arbiter
// Brief    : Round-robin arbiter sharing the register file write port between
//            the ALU writeback and LSU load-data requesters.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              rf_hold,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt_q;

  logic              both_valid;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign both_valid = req0_valid & req1_valid;

  // On contention the requester that did not win last time is served.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && !rf_hold) begin
      if (both_valid) begin
        req0_ready = last_grant;
        req1_ready = ~last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer     = req0_ready | req1_ready;
  assign sel_rd   = req1_ready ? req1_rd   : req0_rd;
  assign sel_data = req1_ready ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_grant <= 1'b1;
      cnt_q      <= '0;
    end else if (!rf_hold) begin
      if (xfer) begin
        waddr_q    <= sel_rd;
        wdata_q    <= sel_data;
        wen_q      <= (sel_rd != '0);
        last_grant <= req1_ready;
      end else begin
        wen_q <= 1'b0;
      end
      if (both_valid && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Gating with rst drops a pending write during the reset cycle itself.
  assign rf_wen       = wen_q & ~rf_hold & ~rst;
  assign rf_waddr     = rst ? '0 : waddr_q;
  assign rf_wdata     = rst ? '0 : wdata_q;
  assign conflict_cnt = rst ? '0 : cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wr_arbiter
// Brief    : Directed self-checking bench for rf_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid, rf_hold;
  logic              req0_ready, req1_ready, rf_wen;
  logic [ADDR_W-1:0] req0_rd, req1_rd, rf_waddr;
  logic [DATA_W-1:0] req0_data, req1_data, rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  rf_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_hold(rf_hold), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rf_hold = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b0; req1_rd = '0;   req1_data = '0;
    tick(); tick();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_wen",    {31'd0, rf_wen},     32'd0);
    chk("rst_waddr",  {27'd0, rf_waddr},   32'd0);
    chk("rst_wdata",  rf_wdata,            32'd0);
    chk("rst_cnt",    {16'd0, conflict_cnt}, 32'd0);

    // Single req0 write, rd=5
    rst = 1'b0; req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h10;
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t1_wen",   {31'd0, rf_wen},   32'd1);
    chk("t1_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("t1_wdata", rf_wdata,          32'h10);
    tick();
    chk("t1_idle_wen", {31'd0, rf_wen}, 32'd0);

    // Both valid straight out of reset: strict alternation 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hA;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_ready0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_ready1_%0d", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("t2_wen_%0d", i),   {31'd0, rf_wen},   32'd1);
      chk($sformatf("t2_waddr_%0d", i), {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("t2_wdata_%0d", i), rf_wdata,          (i % 2 == 0) ? 32'hA : 32'hB);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_cnt", {16'd0, conflict_cnt}, 32'd4);

    // Write to x0 is accepted but never reaches the RF
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hDEAD_BEEF;
    #1;
    chk("t3_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("t3_wen",   {31'd0, rf_wen}, 32'd0);
    chk("t3_wdata", rf_wdata,        32'hDEAD_BEEF);

    // Hold after a registered write: presented exactly once after release
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h55;
    #1;
    chk("t4_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    rf_hold = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h9;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_hold_wen_%0d", i), {31'd0, rf_wen},     32'd0);
      chk($sformatf("t4_hold_rdy_%0d", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rf_hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("t4_wen",   {31'd0, rf_wen},   32'd1);
    chk("t4_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("t4_wdata", rf_wdata,          32'h55);
    chk("t4_cnt",   {16'd0, conflict_cnt}, 32'd4);
    tick();
    chk("t4_once", {31'd0, rf_wen}, 32'd0);

    // Reset right after a transfer: write dropped, req0 favoured afterwards
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
    #1;
    chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    rst = 1'b1;
    req0_rd = 5'd11; req0_data = 32'h111;
    req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'h222;
    #1;
    chk("t5_rst_wen",   {31'd0, rf_wen},   32'd0);
    chk("t5_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("t5_rst_wdata", rf_wdata,          32'd0);
    chk("t5_rst_cnt",   {16'd0, conflict_cnt}, 32'd0);
    chk("t5_rst_rdy",   {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t5_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("t5_waddr", {27'd0, rf_waddr}, 32'd11);
    chk("t5_cnt",   {16'd0, conflict_cnt}, 32'd1);

    // Counter saturation: already at 1, both valid keeps counting
    repeat (65533) @(posedge clk);
    #1;
    chk("t6_cnt_pre", {16'd0, conflict_cnt}, 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_cnt_sat", {16'd0, conflict_cnt}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
